// File: rtl/trdb_trace_ctrl_pkg.sv
// trdb_trace_ctrl_pkg: shared state encoding and defaults for the trace on/off controller
package trdb_trace_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, START, TRACE, STOP, DRAIN} trace_ctrl_state_e;

    localparam int TRDB_CTRL_DRAIN_DEFAULT   = 4;
    localparam int TRDB_CTRL_TIMEOUT_DEFAULT = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trdb_trace_ctrl_if.sv
// trdb_trace_ctrl_if: request/ack bundle between trigger/filter/emitter and the trace controller
interface trdb_trace_ctrl_if;

    logic trace_activated_i;
    logic trace_req_on_i;
    logic trace_req_off_i;
    logic start_pkt_req_o;
    logic start_pkt_ack_i;
    logic stop_pkt_req_o;
    logic stop_pkt_ack_i;
    logic trace_enable_o;
    logic clk_en_o;
    logic busy_o;
    logic timeout_o;

    modport master (
        output trace_activated_i, trace_req_on_i, trace_req_off_i, start_pkt_ack_i, stop_pkt_ack_i,
        input  start_pkt_req_o, stop_pkt_req_o, trace_enable_o, clk_en_o, busy_o, timeout_o
    );

    modport slave (
        input  trace_activated_i, trace_req_on_i, trace_req_off_i, start_pkt_ack_i, stop_pkt_ack_i,
        output start_pkt_req_o, stop_pkt_req_o, trace_enable_o, clk_en_o, busy_o, timeout_o
    );

endinterface

// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl: Moore FSM sequencing trace start/stop packets, drain and clock-gate enable.
// Optional macro TRDB_CTRL_TIMEOUT_EN adds an ack timeout on START/STOP with a timeout_o pulse.
module trdb_trace_ctrl
    import trdb_trace_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = TRDB_CTRL_DRAIN_DEFAULT,
    parameter int TIMEOUT      = TRDB_CTRL_TIMEOUT_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    trdb_trace_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(max_int(DRAIN_CYCLES, TIMEOUT) + 1);
    localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);
`ifdef TRDB_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] ACK_LD = CNT_W'(TIMEOUT - 1);
`else
    localparam logic [CNT_W-1:0] ACK_LD = '0;
`endif

    trace_ctrl_state_e r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_pend, w_pend;
    logic              r_start, r_stop, r_en, r_clk_en;
    logic              w_off, w_zero;

    assign w_off  = bus.trace_req_off_i | ~bus.trace_activated_i;
    assign w_zero = (r_cnt == '0);

`ifdef TRDB_CTRL_TIMEOUT_EN
    logic r_timeout, w_to;
    assign bus.timeout_o = r_timeout;
`else
    assign bus.timeout_o = 1'b0;
`endif

    // next-state, shared counter and pending-off decode
    always_comb begin
        w_next = r_state;
        w_cnt  = w_zero ? '0 : r_cnt - 1'b1;
        w_pend = r_pend;
`ifdef TRDB_CTRL_TIMEOUT_EN
        w_to   = 1'b0;
`endif
        case (r_state)
            IDLE: if (bus.trace_activated_i & bus.trace_req_on_i & ~bus.trace_req_off_i) begin
                w_next = START;
                w_cnt  = ACK_LD;
                w_pend = 1'b0;
            end
            START: begin
                w_pend = r_pend | w_off;
                if (bus.start_pkt_ack_i) begin
                    w_next = (r_pend | w_off) ? STOP : TRACE;
                    w_cnt  = (r_pend | w_off) ? ACK_LD : w_cnt;
                    w_pend = 1'b0;
                end
`ifdef TRDB_CTRL_TIMEOUT_EN
                else if (w_zero) begin
                    w_next = IDLE;
                    w_pend = 1'b0;
                    w_to   = 1'b1;
                end
`endif
            end
            TRACE: if (w_off) begin
                w_next = STOP;
                w_cnt  = ACK_LD;
            end
            STOP: if (bus.stop_pkt_ack_i) begin
                w_next = DRAIN;
                w_cnt  = DRAIN_LD;
            end
`ifdef TRDB_CTRL_TIMEOUT_EN
            else if (w_zero) begin
                w_next = DRAIN;
                w_cnt  = DRAIN_LD;
                w_to   = 1'b1;
            end
`endif
            DRAIN: if (w_zero) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state, counter and outputs registered from the next state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_en     <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt;
            r_pend   <= w_pend;
            r_start  <= (w_next == START);
            r_stop   <= (w_next == STOP);
            r_en     <= (w_next == TRACE);
            r_clk_en <= (w_next != IDLE);
        end
    end

`ifdef TRDB_CTRL_TIMEOUT_EN
    // one-cycle timeout pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_timeout <= 1'b0;
        else       r_timeout <= w_to;
    end
`endif

    assign bus.start_pkt_req_o = r_start;
    assign bus.stop_pkt_req_o  = r_stop;
    assign bus.trace_enable_o  = r_en;
    assign bus.clk_en_o        = r_clk_en;
    assign bus.busy_o          = r_clk_en;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// tb_trdb_trace_ctrl: directed checks of the trace controller handshake, drain, timeout and reset
module tb_trdb_trace_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    trdb_trace_ctrl_if bus ();

    trdb_trace_ctrl #(.DRAIN_CYCLES(4), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_start"}, int'(bus.start_pkt_req_o), 0);
        chk({tag, "_stop"},  int'(bus.stop_pkt_req_o), 0);
        chk({tag, "_en"},    int'(bus.trace_enable_o), 0);
        chk({tag, "_clken"}, int'(bus.clk_en_o), 0);
        chk({tag, "_busy"},  int'(bus.busy_o), 0);
        chk({tag, "_to"},    int'(bus.timeout_o), 0);
    endtask

    task automatic on_pulse();
        bus.trace_req_on_i = 1'b1;
        tick();
        bus.trace_req_on_i = 1'b0;
    endtask

    task automatic ack_start();
        bus.start_pkt_ack_i = 1'b1;
        tick();
        bus.start_pkt_ack_i = 1'b0;
    endtask

    // acks the stop packet and counts clk_en cycles until idle
    task automatic ack_stop_drain(input string tag);
        int n;
        n = 0;
        bus.stop_pkt_ack_i = 1'b1;
        tick();
        bus.stop_pkt_ack_i = 1'b0;
        chk({tag, "_stop_drop"}, int'(bus.stop_pkt_req_o), 0);
        while (bus.clk_en_o && n < 20) begin
            chk({tag, "_drain_en"}, int'(bus.trace_enable_o), 0);
            n++;
            tick();
        end
        chk({tag, "_drain_len"}, n, 4);
        chk({tag, "_idle"}, int'(bus.busy_o), 0);
    endtask

    initial begin
        int n;
        bus.trace_activated_i = 1'b1;
        bus.trace_req_on_i    = 1'b0;
        bus.trace_req_off_i   = 1'b0;
        bus.start_pkt_ack_i   = 1'b0;
        bus.stop_pkt_ack_i    = 1'b0;
        tick(3);
        outs_zero("rst");
        rst = 1'b0;
        tick(2);
        outs_zero("idle");

        on_pulse();
        chk("t1_start_req", int'(bus.start_pkt_req_o), 1);
        chk("t1_clken", int'(bus.clk_en_o), 1);
        chk("t1_en_lo", int'(bus.trace_enable_o), 0);
        tick(2);
        chk("t1_start_held", int'(bus.start_pkt_req_o), 1);
        ack_start();
        chk("t1_trace_en", int'(bus.trace_enable_o), 1);
        chk("t1_start_drop", int'(bus.start_pkt_req_o), 0);
        chk("t1_busy", int'(bus.busy_o), 1);

        bus.trace_req_off_i = 1'b1;
        tick();
        bus.trace_req_off_i = 1'b0;
        chk("t2_en_lo", int'(bus.trace_enable_o), 0);
        chk("t2_stop_req", int'(bus.stop_pkt_req_o), 1);
        tick(2);
        chk("t2_stop_held", int'(bus.stop_pkt_req_o), 1);
        ack_stop_drain("t2");

        bus.trace_req_on_i  = 1'b1;
        bus.trace_req_off_i = 1'b1;
        tick(3);
        bus.trace_req_on_i  = 1'b0;
        bus.trace_req_off_i = 1'b0;
        chk("t3_idle_both", int'(bus.busy_o), 0);
        chk("t3_idle_nostart", int'(bus.start_pkt_req_o), 0);
        on_pulse();
        ack_start();
        chk("t3_trace", int'(bus.trace_enable_o), 1);
        bus.trace_req_on_i  = 1'b1;
        bus.trace_req_off_i = 1'b1;
        tick();
        bus.trace_req_on_i  = 1'b0;
        bus.trace_req_off_i = 1'b0;
        chk("t3_both_stop", int'(bus.stop_pkt_req_o), 1);
        chk("t3_both_en", int'(bus.trace_enable_o), 0);
        ack_stop_drain("t3");

        on_pulse();
        bus.trace_req_off_i = 1'b1;
        tick();
        bus.trace_req_off_i = 1'b0;
        chk("t4_start_held", int'(bus.start_pkt_req_o), 1);
        chk("t4_en0", int'(bus.trace_enable_o), 0);
        tick();
        chk("t4_start_held2", int'(bus.start_pkt_req_o), 1);
        ack_start();
        chk("t4_to_stop", int'(bus.stop_pkt_req_o), 1);
        chk("t4_en1", int'(bus.trace_enable_o), 0);
        ack_stop_drain("t4");

        on_pulse();
`ifdef TRDB_CTRL_TIMEOUT_EN
        n = 0;
        while (bus.start_pkt_req_o && n < 50) begin
            chk("t5_to_early", int'(bus.timeout_o), 0);
            n++;
            tick();
        end
        chk("t5_start_len", n, 8);
        chk("t5_to_pulse", int'(bus.timeout_o), 1);
        chk("t5_idle", int'(bus.busy_o), 0);
        tick();
        chk("t5_to_one", int'(bus.timeout_o), 0);
        on_pulse();
        ack_start();
`else
        n = 0;
        while (bus.start_pkt_req_o && n < 1000) begin
            n++;
            tick();
        end
        chk("t5_start_held", n, 1000);
        chk("t5_no_to", int'(bus.timeout_o), 0);
        ack_start();
`endif
        chk("t6_trace", int'(bus.trace_enable_o), 1);
        bus.trace_activated_i = 1'b0;
        tick();
        bus.trace_activated_i = 1'b1;
        chk("t6_stop", int'(bus.stop_pkt_req_o), 1);
        #2 rst = 1'b1;
        #1 outs_zero("t6_async");
        tick();
        rst = 1'b0;
        bus.stop_pkt_ack_i = 1'b1;
        tick();
        bus.stop_pkt_ack_i = 1'b0;
        outs_zero("t6_stray");
        tick(2);
        outs_zero("t6_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
